chip_bus_bridge: RTL and testbench

//  Parametrised bridge between the byte-wide pin bus (valid/wen/addr/wdata/rdata, after the pad ring)
//  and a wider core bus with a valid/ready handshake. Assembles byte writes into core words, fetches

---
 rtl/chip_bus_bridge_if.sv | 33 +++
 rtl/chip_bus_bridge.sv | 171 +++++++++++++++++
 tb/tb_chip_bus_bridge.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/chip_bus_bridge_if.sv
// rtl/chip_bus_bridge_if.sv - pin-side byte bus and core-side word bus bundled for the pin/core bridge
interface chip_bus_bridge_if #(
    parameter int PIN_DW  = 8,
    parameter int PIN_AW  = 8,
    parameter int CORE_DW = 32
);
    localparam int LB      = $clog2(CORE_DW / PIN_DW);
    localparam int CORE_AW = PIN_AW - LB;

    logic                valid;
    logic                wen;
    logic [PIN_AW-1:0]   addr;
    logic [PIN_DW-1:0]   wdata;
    logic [PIN_DW-1:0]   rdata;
    logic                busy;
    logic                core_valid;
    logic                core_wen;
    logic [CORE_AW-1:0]  core_addr;
    logic [CORE_DW-1:0]  core_wdata;
    logic [CORE_DW-1:0]  core_rdata;
    logic                core_ready;

    // master = pads plus core (the environment), slave = the bridge itself
    modport master (
        output valid, wen, addr, wdata, core_rdata, core_ready,
        input  rdata, busy, core_valid, core_wen, core_addr, core_wdata
    );

    modport slave (
        input  valid, wen, addr, wdata, core_rdata, core_ready,
        output rdata, busy, core_valid, core_wen, core_addr, core_wdata
    );
endinterface

// File: rtl/chip_bus_bridge.sv
// rtl/chip_bus_bridge.sv - byte pin bus to wide core bus bridge; optional handshake timeout via BRIDGE_TIMEOUT_EN
module chip_bus_bridge #(
    parameter int PIN_DW  = 8,
    parameter int PIN_AW  = 8,
    parameter int CORE_DW = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             resetn,
    chip_bus_bridge_if.slave bus
);
    localparam int LANES   = CORE_DW / PIN_DW;
    localparam int LB      = $clog2(LANES);
    localparam int CORE_AW = PIN_AW - LB;
    localparam logic [LB-1:0] LAST_LANE = LB'(LANES - 1);

    if ((CORE_DW % PIN_DW) != 0 || LANES < 2 || TIMEOUT < 1) begin : g_bad_cfg
        $error("chip_bus_bridge: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ} state_t;

    state_t state_q, state_d;

    logic [LB-1:0]               lane;
    logic [CORE_AW-1:0]          word_addr;
    logic                        is_status;
    logic                        strobe_idle;
    logic                        start_wr;
    logic                        start_rd;
    logic                        rd_status;
    logic                        done;
    logic                        expire;
    logic                        busy;
    logic                        core_wen;
    logic                        timeout_bit;
    logic [PIN_DW-1:0]           status_byte;

    logic [(LANES-1)*PIN_DW-1:0] wbuf_q;
    logic [CORE_DW-1:0]          rbuf_q;
    logic [CORE_DW-1:0]          core_wdata_q;
    logic [CORE_AW-1:0]          core_addr_q;
    logic [PIN_DW-1:0]           rdata_q;
    logic                        overrun_q;

    assign lane        = bus.addr[LB-1:0];
    assign word_addr   = bus.addr[PIN_AW-1:LB];
    assign is_status   = &bus.addr;
    assign strobe_idle = bus.valid & (state_q == IDLE);
    // STATUS sits in the last lane, so a lane-0 read can never alias it
    assign start_wr    = strobe_idle & bus.wen & (lane == LAST_LANE) & ~is_status;
    assign start_rd    = strobe_idle & ~bus.wen & (lane == '0);
    assign rd_status   = strobe_idle & ~bus.wen & is_status;
    assign done        = busy & bus.core_ready;

`ifdef BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;

    // core_ready on the expiry cycle still completes normally
    assign expire      = busy & ~bus.core_ready & (cnt_q == CNT_W'(TIMEOUT - 1));
    assign timeout_bit = timeout_q;

    always_ff @(posedge clk) begin
        if (!resetn || !busy) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            timeout_q <= 1'b0;
        end else if (expire) begin
            timeout_q <= 1'b1;
        end else if (rd_status) begin
            timeout_q <= 1'b0;
        end
    end
`else
    assign expire      = 1'b0;
    assign timeout_bit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_wr) begin
                    state_d = WR_REQ;
                end else if (start_rd) begin
                    state_d = RD_REQ;
                end
            end
            WR_REQ, RD_REQ: begin
                if (done || expire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != IDLE);
        core_wen = (state_q == WR_REQ);
    end

    always_comb begin
        status_byte      = '0;
        status_byte[2:0] = {overrun_q, timeout_bit, busy};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wbuf_q       <= '0;
            rbuf_q       <= '0;
            core_wdata_q <= '0;
            core_addr_q  <= '0;
            rdata_q      <= '0;
            overrun_q    <= 1'b0;
        end else begin
            if (strobe_idle && bus.wen && lane != LAST_LANE) begin
                wbuf_q[lane*PIN_DW +: PIN_DW] <= bus.wdata;
            end
            if (start_wr) begin
                core_wdata_q <= {bus.wdata, wbuf_q};
                core_addr_q  <= word_addr;
            end
            if (start_rd) begin
                core_addr_q <= word_addr;
            end
            if (strobe_idle && !bus.wen && !is_status && lane != '0) begin
                rdata_q <= rbuf_q[lane*PIN_DW +: PIN_DW];
            end
            // the read returns the flags as they were before this clear
            if (rd_status) begin
                rdata_q   <= status_byte;
                overrun_q <= 1'b0;
            end
            if (bus.valid && busy) begin
                overrun_q <= 1'b1;
            end
            if (done && state_q == RD_REQ) begin
                rbuf_q  <= bus.core_rdata;
                rdata_q <= bus.core_rdata[PIN_DW-1:0];
            end
            if (expire && state_q == RD_REQ) begin
                rdata_q <= '1;
            end
        end
    end

    assign bus.rdata      = rdata_q;
    assign bus.busy       = busy;
    assign bus.core_valid = busy;
    assign bus.core_wen   = core_wen;
    assign bus.core_addr  = core_addr_q;
    assign bus.core_wdata = core_wdata_q;
endmodule

// File: tb/tb_chip_bus_bridge.sv
// tb/tb_chip_bus_bridge.sv - self-checking bench for chip_bus_bridge with a transaction-level reference model
module tb_chip_bus_bridge;
    logic clk;
    logic resetn;

    chip_bus_bridge_if #(.PIN_DW(8), .PIN_AW(8), .CORE_DW(32)) bus ();

    chip_bus_bridge #(.PIN_DW(8), .PIN_AW(8), .CORE_DW(32), .TIMEOUT(8)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  m_wbuf [3];
    logic [31:0] m_rbuf;
    logic [7:0]  m_rdata;
    bit          m_ovr;
    bit          m_tmo;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_wbuf[i] = 8'h00;
        m_rbuf  = 32'h0;
        m_rdata = 8'h00;
        m_ovr   = 1'b0;
        m_tmo   = 1'b0;
    endtask

    // one pin transfer; if it starts a core request, answer it after 'delay' idle cycles,
    // optionally throwing a stray strobe at wait cycle 'drop_at'
    task automatic xfer(input bit w, input logic [7:0] a, input logic [7:0] d,
                        input int delay, input int drop_at, input logic [31:0] crd);
        logic [1:0]  ln;
        bit          st;
        bit          req_wr;
        bit          req_rd;
        logic [31:0] exp_wd;
        ln     = a[1:0];
        st     = (a == 8'hFF);
        req_wr = w && !st && ln == 2'd3;
        req_rd = !w && ln == 2'd0;
        exp_wd = 32'h0;
        if (w && !st && ln != 2'd3) m_wbuf[ln] = d;
        if (req_wr) exp_wd = {d, m_wbuf[2], m_wbuf[1], m_wbuf[0]};
        if (!w && st) begin
            m_rdata = {5'b0, m_ovr, m_tmo, 1'b0};
            m_ovr   = 1'b0;
            m_tmo   = 1'b0;
        end else if (!w && ln != 2'd0) begin
            m_rdata = m_rbuf[ln*8 +: 8];
        end

        @(negedge clk);
        bus.valid      = 1'b1;
        bus.wen        = w;
        bus.addr       = a;
        bus.wdata      = d;
        bus.core_ready = 1'b0;
        bus.core_rdata = crd;
        @(negedge clk);
        bus.valid = 1'b0;

        if (req_wr || req_rd) begin
            chk("req_valid", bus.core_valid, 1);
            chk("req_wen", bus.core_wen, req_wr);
            chk("req_addr", bus.core_addr, a[7:2]);
            if (req_wr) chk("req_wdata", bus.core_wdata, exp_wd);
            for (int i = 0; i < delay; i++) begin
                if (i == drop_at) begin
                    bus.valid = 1'b1;
                    bus.wen   = 1'($urandom);
                    bus.addr  = 8'($urandom);
                    bus.wdata = 8'($urandom);
                    m_ovr     = 1'b1;
                end
                @(negedge clk);
                bus.valid = 1'b0;
                chk("wait_busy", bus.busy, 1);
                chk("wait_addr", bus.core_addr, a[7:2]);
                chk("wait_rdata", bus.rdata, m_rdata);
                if (req_wr) chk("wait_wdata", bus.core_wdata, exp_wd);
            end
            bus.core_ready = 1'b1;
            @(negedge clk);
            bus.core_ready = 1'b0;
            if (req_rd) begin
                m_rbuf  = crd;
                m_rdata = crd[7:0];
            end
        end
        chk("idle_busy", bus.busy, 0);
        chk("idle_core_valid", bus.core_valid, 0);
        chk("rdata", bus.rdata, m_rdata);
    endtask

    initial begin
        int cyc;
        bus.valid      = 1'b0;
        bus.wen        = 1'b0;
        bus.addr       = 8'h00;
        bus.wdata      = 8'h00;
        bus.core_ready = 1'b0;
        bus.core_rdata = 32'h0;
        resetn         = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        chk("rst_rdata", bus.rdata, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_core_valid", bus.core_valid, 0);
        chk("rst_core_wen", bus.core_wen, 0);
        chk("rst_core_addr", bus.core_addr, 0);
        chk("rst_core_wdata", bus.core_wdata, 0);

        xfer(1, 8'h14, 8'h11, 0, -1, 32'h0);
        xfer(1, 8'h15, 8'h22, 0, -1, 32'h0);
        xfer(1, 8'h16, 8'h33, 0, -1, 32'h0);
        xfer(1, 8'h17, 8'h44, 0, -1, 32'h0);
        chk("dir_word", bus.core_wdata, 32'h44332211);

        xfer(0, 8'h14, 8'h00, 0, -1, 32'hA1B2C3D4);
        chk("dir_rd_lane0", bus.rdata, 8'hD4);
        xfer(0, 8'h16, 8'h00, 0, -1, 32'h0);
        chk("dir_rd_lane2", bus.rdata, 8'hB2);

        @(negedge clk);
        bus.valid = 1'b1; bus.wen = 1'b0; bus.addr = 8'h08;
        @(negedge clk);
        bus.valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                bus.valid = 1'b1; bus.wen = 1'b1; bus.addr = 8'h20; bus.wdata = 8'h5A;
            end
            @(negedge clk);
            bus.valid = 1'b0;
            chk("ovr_wait_busy", bus.busy, 1);
        end
        bus.core_rdata = 32'h01020304;
        bus.core_ready = 1'b1;
        @(negedge clk);
        bus.core_ready = 1'b0;
        m_rbuf  = 32'h01020304;
        m_rdata = 8'h04;
        m_ovr   = 1'b1;
        chk("ovr_rd_done", bus.rdata, 8'h04);
        xfer(0, 8'hFF, 8'h00, 0, -1, 32'h0);
        chk("dir_status_ovr", bus.rdata, 8'h04);
        xfer(0, 8'hFF, 8'h00, 0, -1, 32'h0);
        chk("dir_status_clr", bus.rdata, 8'h00);
        xfer(0, 8'h21, 8'h00, 0, -1, 32'h0);
        chk("drop_no_rbuf_change", bus.rdata, 8'h03);

        for (int n = 0; n < 300; n++) begin
            bit          w;
            logic [7:0]  a;
            int          dly;
            int          drop;
            w    = 1'($urandom_range(0, 1));
            a    = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom);
            dly  = $urandom_range(0, 5);
            drop = (dly > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, dly - 1) : -1;
            xfer(w, a, 8'($urandom), dly, drop, $urandom);
        end

`ifdef BRIDGE_TIMEOUT_EN
        xfer(0, 8'hFF, 8'h00, 0, -1, 32'h0);
        @(negedge clk);
        bus.valid = 1'b1; bus.wen = 1'b0; bus.addr = 8'h04; bus.core_ready = 1'b0;
        @(negedge clk);
        bus.valid = 1'b0;
        cyc = 0;
        while (bus.busy && cyc < 20) begin
            cyc++;
            @(negedge clk);
        end
        chk("tmo_cycles", cyc, 8);
        m_rdata = 8'hFF;
        m_tmo   = 1'b1;
        chk("tmo_rdata", bus.rdata, 8'hFF);
        xfer(0, 8'hFF, 8'h00, 0, -1, 32'h0);
        chk("tmo_status", bus.rdata, 8'h02);
`endif

        @(negedge clk);
        bus.valid = 1'b1; bus.wen = 1'b0; bus.addr = 8'h08; bus.core_ready = 1'b0;
        @(negedge clk);
        bus.valid = 1'b0;
        chk("prerst_core_valid", bus.core_valid, 1);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        chk("midrst_core_valid", bus.core_valid, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_rdata", bus.rdata, 0);
        chk("midrst_core_addr", bus.core_addr, 0);
        xfer(0, 8'hFF, 8'h00, 0, -1, 32'h0);
        chk("midrst_status", bus.rdata, 8'h00);

        xfer(1, 8'hFF, 8'hA5, 0, -1, 32'h0);
        chk("stwr_no_req", bus.core_valid, 0);
        xfer(0, 8'hFF, 8'h00, 0, -1, 32'h0);
        chk("stwr_status", bus.rdata, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
